color_dominance_analyzer: RTL and testbench
===========================================

# color_dominance_analyzer

Parametrised frame analyser for the camera path. On a start pulse it scans a frame buffer of RGB pixels over a synchronous read port and classifies each pixel as red, green, blue or none. It counts each class and reports the dominant colour as a one-hot code with a done pulse. It sits between the camera frame buffer and the SoC peripheral registers, and replaces the fixed RGB332, 19200-pixel analyser.

## Interface
- `NUM_PIXELS`, 19200: pixels scanned per frame (≥1).
- `ADDR_W`, 15: buffer address width; `BASE_ADDR + NUM_PIXELS - 1` must fit.
- `BASE_ADDR`, 0: first buffer address scanned.
- `R_BITS`/`G_BITS`/`B_BITS`, 3/3/2: channel widths; pixel = {R,G,B}, MSB-first.
- `MIN_COUNT`, 0: winning count must be strictly greater than this, else no colour.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `init`  in  1  start request, sampled only in IDLE.
- `data`  in  R_BITS+G_BITS+B_BITS  pixel read data, valid 1 cycle after `rd_en`.
- `rd_en`  out  1  buffer read strobe.
- `addr`  out  ADDR_W  buffer read address.
- `busy`  out  1  high from the cycle after `init` accepted until return to IDLE.
- `done`  out  1  one-cycle pulse, result valid.
- `valor`  out  3  {R,G,B} one-hot dominant colour; 000 = none/tie.

## Operation
- FSM: IDLE → SCAN → DRAIN → DECIDE → DONE → IDLE.
- IDLE: `init`=1 clears the three counters and the address counter, then moves to SCAN.
- SCAN: for NUM_PIXELS cycles, `rd_en`=1 and `addr` = BASE_ADDR+i, with i = 0..NUM_PIXELS-1.
- A one-stage valid pipe tags returning data. Each valid pixel is classified and accumulated in the cycle it returns.
- DRAIN: one cycle, `rd_en`=0; the last pixel is accumulated.
- Classification (channel MSB high = "set"):
  - red = R set, G and B clear.
  - green = G set, R and B clear.
  - blue = B set, R and G clear.
  - Any other combination counts in no class.
- Counters are `$clog2(NUM_PIXELS+1)` bits wide, so no overflow is possible.
- DECIDE:
  - If one count is strictly greater than both others and greater than MIN_COUNT, `valor` is its one-hot code.
  - Otherwise `valor` is 000.
  - `valor` is registered here.
- DONE: `done`=1 for one cycle, then IDLE. `valor` holds until the next DECIDE or reset.
- `init` outside IDLE is ignored; there is no queuing.

## Timing
- Reset values: `addr`=0, `rd_en`=0, `busy`=0, `done`=0, `valor`=000, counters 0, state IDLE.
- Take edge 0 as the edge where `init` is sampled.
  - Edges 1..N present addresses 0..N-1.
  - Edge N+1 is DRAIN.
  - Edge N+2 is DECIDE and registers `valor`.
  - `done`=1 during the cycle after edge N+3 (DONE state).
  - Total latency is N+3 cycles from `init` to the `done` rise.
- `busy` falls in the same cycle `done` is high, so `init` is accepted again from the cycle after `done`.
- `rst` mid-scan or mid-decision aborts immediately:
  - All outputs return to their reset values, including `valor`.
  - No `done` is issued.
- NUM_PIXELS=1: exactly one read, latency 4.
- `addr` only advances in SCAN. It never wraps past BASE_ADDR+NUM_PIXELS-1.

## Configuration
- `ANALYZER_COUNTS_OUT_EN` defined: adds outputs `cnt_r`, `cnt_g`, `cnt_b` (counter width each).
  - Registered at DECIDE together with `valor`, held until the next DECIDE.
  - Reset to 0.
- Not defined: these ports and registers do not exist; the counters stay internal.

## Structure
- Package `analyzer_pkg`:
  - State enum (IDLE, SCAN, DRAIN, DECIDE, DONE).
  - Colour codes COLOR_NONE=3'b000, COLOR_RED=3'b100, COLOR_GREEN=3'b010, COLOR_BLUE=3'b001.
- Sub-module `pixel_classifier`: combinational, parametrised by channel widths. Maps `data` to the one-hot class {is_r, is_g, is_b}, or all zero.
- Top level holds the FSM, address counter, valid pipe, counters and decision compare.

## Test plan
- N=16, 10 pure-red pixels (8'hE0), 3 green (8'h1C), 3 blue (8'h03) -> `valor`=100, `done` pulse at init+19 cycles, addr sweeps 0..15 once.
- N=16, 6 red, 6 green, 4 blue -> tie, `valor`=000; with `ANALYZER_COUNTS_OUT_EN`, `cnt_r`=6, `cnt_g`=6, `cnt_b`=4.
- N=16, MIN_COUNT=4, 4 blue, 12 mixed 8'hFF -> 8'hFF counts in no class, so counts are 0/0/4; 4 is not greater than 4, so `valor`=000.
- N=16, `rst` asserted at cycle 8 of SCAN -> `valor`=000, `busy`=0, no `done`. A new `init` then gives a correct full result.
- `init` held high for 40 cycles at N=16 -> exactly two scans, results back-to-back, second scan starting the cycle after the first `done`.
- N=1, BASE_ADDR=0x4B00, pixel 8'h1C -> single read at 0x4B00, `valor`=010, latency 4.

Source files
------------

// File: rtl/analyzer_pkg.sv
// Shared types for the colour dominance analyser:
// FSM state encoding and one-hot colour codes.
package analyzer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        DECIDE,
        DONE
    } state_e;

    localparam logic [2:0] COLOR_NONE  = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;

endpackage

// File: rtl/pixel_classifier.sv
// Combinational pixel classifier: a pixel is a pure colour
// when exactly one channel MSB is set; otherwise no class.
import analyzer_pkg::*;

module pixel_classifier #(
    parameter int R_BITS = 3,
    parameter int G_BITS = 3,
    parameter int B_BITS = 2,
    localparam int PW = R_BITS + G_BITS + B_BITS
) (
    input  logic [PW-1:0] data,
    output logic [2:0]    cls
);

    logic r_set;
    logic g_set;
    logic b_set;
    logic unused_low_bits;

    assign r_set = data[PW-1];
    assign g_set = data[G_BITS+B_BITS-1];
    assign b_set = data[B_BITS-1];

    // Only channel MSBs matter; the remaining bits are deliberately ignored.
    assign unused_low_bits = ^data;

    // One-hot class, all zero for mixed or dark pixels.
    always_comb begin
        cls = COLOR_NONE;
        if (r_set && !g_set && !b_set) cls = COLOR_RED;
        if (g_set && !r_set && !b_set) cls = COLOR_GREEN;
        if (b_set && !r_set && !g_set) cls = COLOR_BLUE;
    end

endmodule

// File: rtl/color_dominance_analyzer.sv
// Frame colour dominance analyser: scans NUM_PIXELS pixels, counts
// pure R/G/B pixels and reports the strict winner as a one-hot code.
// Optional macro ANALYZER_COUNTS_OUT_EN exposes the final counts.
import analyzer_pkg::*;

module color_dominance_analyzer #(
    parameter int NUM_PIXELS = 19200,
    parameter int ADDR_W     = 15,
    parameter int BASE_ADDR  = 0,
    parameter int R_BITS     = 3,
    parameter int G_BITS     = 3,
    parameter int B_BITS     = 2,
    parameter int MIN_COUNT  = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                init,
    input  logic [R_BITS+G_BITS+B_BITS-1:0]     data,
    output logic                                rd_en,
    output logic [ADDR_W-1:0]                   addr,
    output logic                                busy,
    output logic                                done,
    output logic [2:0]                          valor
`ifdef ANALYZER_COUNTS_OUT_EN
    ,
    output logic [$clog2(NUM_PIXELS+1)-1:0]     cnt_r,
    output logic [$clog2(NUM_PIXELS+1)-1:0]     cnt_g,
    output logic [$clog2(NUM_PIXELS+1)-1:0]     cnt_b
`endif
);

    localparam int CW = $clog2(NUM_PIXELS + 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  =
        ADDR_W'(BASE_ADDR + NUM_PIXELS - 1);
    localparam logic [31:0] MIN_U = 32'(MIN_COUNT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        valor_q, valor_d;
    logic [CW-1:0]     cnt_r_q, cnt_r_d;
    logic [CW-1:0]     cnt_g_q, cnt_g_d;
    logic [CW-1:0]     cnt_b_q, cnt_b_d;
`ifdef ANALYZER_COUNTS_OUT_EN
    logic [CW-1:0]     rep_r_q, rep_r_d;
    logic [CW-1:0]     rep_g_q, rep_g_d;
    logic [CW-1:0]     rep_b_q, rep_b_d;
`endif

    logic [2:0] cls;
    logic [2:0] winner;

    pixel_classifier #(
        .R_BITS (R_BITS),
        .G_BITS (G_BITS),
        .B_BITS (B_BITS)
    ) u_cls (
        .data (data),
        .cls  (cls)
    );

    // Strict-majority decision with a minimum-count floor.
    always_comb begin
        logic r_win;
        logic g_win;
        logic b_win;
        r_win = (cnt_r_q > cnt_g_q) && (cnt_r_q > cnt_b_q)
             && (32'(cnt_r_q) > MIN_U);
        g_win = (cnt_g_q > cnt_r_q) && (cnt_g_q > cnt_b_q)
             && (32'(cnt_g_q) > MIN_U);
        b_win = (cnt_b_q > cnt_r_q) && (cnt_b_q > cnt_g_q)
             && (32'(cnt_b_q) > MIN_U);
        winner = COLOR_NONE;
        unique case (1'b1)
            r_win:   winner = COLOR_RED;
            g_win:   winner = COLOR_GREEN;
            b_win:   winner = COLOR_BLUE;
            default: winner = COLOR_NONE;
        endcase
    end

    // Next-state, address sweep, accumulation and result capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        vld_d   = rd_en_q;
        valor_d = valor_q;
        cnt_r_d = cnt_r_q;
        cnt_g_d = cnt_g_q;
        cnt_b_d = cnt_b_q;
`ifdef ANALYZER_COUNTS_OUT_EN
        rep_r_d = rep_r_q;
        rep_g_d = rep_g_q;
        rep_b_d = rep_b_q;
`endif

        if (vld_q) begin
            cnt_r_d = cnt_r_q + CW'(cls[2]);
            cnt_g_d = cnt_g_q + CW'(cls[1]);
            cnt_b_d = cnt_b_q + CW'(cls[0]);
        end

        unique case (state_q)
            IDLE: begin
                if (init) begin
                    state_d = SCAN;
                    addr_d  = FIRST_ADDR;
                    cnt_r_d = '0;
                    cnt_g_d = '0;
                    cnt_b_d = '0;
                end
            end
            SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                state_d = DONE;
                valor_d = winner;
`ifdef ANALYZER_COUNTS_OUT_EN
                rep_r_d = cnt_r_q;
                rep_g_d = cnt_g_q;
                rep_b_d = cnt_b_q;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_en_d = (state_d == SCAN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == DONE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valor_q <= COLOR_NONE;
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
`ifdef ANALYZER_COUNTS_OUT_EN
            rep_r_q <= '0;
            rep_g_q <= '0;
            rep_b_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valor_q <= valor_d;
            cnt_r_q <= cnt_r_d;
            cnt_g_q <= cnt_g_d;
            cnt_b_q <= cnt_b_d;
`ifdef ANALYZER_COUNTS_OUT_EN
            rep_r_q <= rep_r_d;
            rep_g_q <= rep_g_d;
            rep_b_q <= rep_b_d;
`endif
        end
    end

    assign rd_en = rd_en_q;
    assign addr  = addr_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign valor = valor_q;
`ifdef ANALYZER_COUNTS_OUT_EN
    assign cnt_r = rep_r_q;
    assign cnt_g = rep_g_q;
    assign cnt_b = rep_b_q;
`endif

endmodule

// File: tb/tb_color_dominance_analyzer.sv
// Directed bench for color_dominance_analyzer: three instances
// (N=16, N=16 with MIN_COUNT=4, N=1 at a high base address).
module tb_color_dominance_analyzer;

    logic clk = 1'b0;
    logic rst;
    logic init_req;
    int   sel;

    always #5 clk = ~clk;

    logic        init_a, init_m, init_s;
    logic [7:0]  data_a, data_m, data_s;
    logic        rd_a, rd_m, rd_s;
    logic [14:0] addr_a, addr_m, addr_s;
    logic        busy_a, busy_m, busy_s;
    logic        done_a, done_m, done_s;
    logic [2:0]  valor_a, valor_m, valor_s;
`ifdef ANALYZER_COUNTS_OUT_EN
    logic [4:0]  cr_a, cg_a, cb_a;
    logic [4:0]  cr_m, cg_m, cb_m;
    logic [0:0]  cr_s, cg_s, cb_s;
`endif

    logic [7:0] mem_a [16];
    logic [7:0] mem_m [16];
    logic [7:0] mem_s;
    logic [7:0] pat   [16];

    assign init_a = init_req && (sel == 0);
    assign init_m = init_req && (sel == 1);
    assign init_s = init_req && (sel == 2);

    color_dominance_analyzer #(
        .NUM_PIXELS (16)
    ) dut_a (
        .clk   (clk),
        .rst   (rst),
        .init  (init_a),
        .data  (data_a),
        .rd_en (rd_a),
        .addr  (addr_a),
        .busy  (busy_a),
        .done  (done_a),
        .valor (valor_a)
`ifdef ANALYZER_COUNTS_OUT_EN
        ,
        .cnt_r (cr_a),
        .cnt_g (cg_a),
        .cnt_b (cb_a)
`endif
    );

    color_dominance_analyzer #(
        .NUM_PIXELS (16),
        .MIN_COUNT  (4)
    ) dut_m (
        .clk   (clk),
        .rst   (rst),
        .init  (init_m),
        .data  (data_m),
        .rd_en (rd_m),
        .addr  (addr_m),
        .busy  (busy_m),
        .done  (done_m),
        .valor (valor_m)
`ifdef ANALYZER_COUNTS_OUT_EN
        ,
        .cnt_r (cr_m),
        .cnt_g (cg_m),
        .cnt_b (cb_m)
`endif
    );

    color_dominance_analyzer #(
        .NUM_PIXELS (1),
        .BASE_ADDR  ('h4B00)
    ) dut_s (
        .clk   (clk),
        .rst   (rst),
        .init  (init_s),
        .data  (data_s),
        .rd_en (rd_s),
        .addr  (addr_s),
        .busy  (busy_s),
        .done  (done_s),
        .valor (valor_s)
`ifdef ANALYZER_COUNTS_OUT_EN
        ,
        .cnt_r (cr_s),
        .cnt_g (cg_s),
        .cnt_b (cb_s)
`endif
    );

    // Synchronous-read frame buffers, one cycle of latency.
    always @(posedge clk) begin
        if (rd_a) data_a <= mem_a[addr_a[3:0]];
        if (rd_m) data_m <= mem_m[addr_m[3:0]];
        if (rd_s) data_s <= mem_s;
    end

    logic        mon_rd, mon_busy, mon_done;
    logic [14:0] mon_addr;
    logic [2:0]  mon_valor;

    always_comb begin
        mon_rd    = rd_a;
        mon_addr  = addr_a;
        mon_busy  = busy_a;
        mon_done  = done_a;
        mon_valor = valor_a;
        case (sel)
            1: begin
                mon_rd    = rd_m;
                mon_addr  = addr_m;
                mon_busy  = busy_m;
                mon_done  = done_m;
                mon_valor = valor_m;
            end
            2: begin
                mon_rd    = rd_s;
                mon_addr  = addr_s;
                mon_busy  = busy_s;
                mon_done  = done_s;
                mon_valor = valor_s;
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int nr, input int ng, input int nb,
                        input logic [7:0] pr, input logic [7:0] pg,
                        input logic [7:0] pb, input logic [7:0] po);
        for (int i = 0; i < 16; i++) begin
            if (i < nr) pat[i] = pr;
            else if (i < nr + ng) pat[i] = pg;
            else if (i < nr + ng + nb) pat[i] = pb;
            else pat[i] = po;
        end
    endtask

    task automatic run_scan(input int n, input int base,
                            output int lat, output int nrd,
                            output int sweep_ok, output int busy_ok);
        lat      = -1;
        nrd      = 0;
        sweep_ok = 1;
        busy_ok  = 0;
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n + 40; k++) begin
            @(negedge clk);
            if (k == 0) init_req = 1'b0;
            if (mon_rd) begin
                if (int'(mon_addr) != base + nrd) sweep_ok = 0;
                nrd++;
            end
            if (mon_done) begin
                lat     = k;
                busy_ok = mon_busy ? 0 : 1;
                break;
            end
        end
    endtask

    int lat, nrd, swp, bok;
    int nd, d0, d1, rd20, ad20;

    initial begin
        rst      = 1'b1;
        init_req = 1'b0;
        sel      = 0;
        mem_s    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_addr",  int'(addr_a),  0);
        check_eq("rst_rd_en", int'(rd_a),    0);
        check_eq("rst_busy",  int'(busy_a),  0);
        check_eq("rst_done",  int'(done_a),  0);
        check_eq("rst_valor", int'(valor_a), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Red majority: 10 red, 3 green, 3 blue.
        fill(10, 3, 3, 8'hE0, 8'h1C, 8'h03, 8'h00);
        mem_a = pat;
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("red_latency", lat, 19);
        check_eq("red_reads",   nrd, 16);
        check_eq("red_sweep",   swp, 1);
        check_eq("red_busy_lo", bok, 1);
        check_eq("red_valor",   int'(mon_valor), 3'b100);
        repeat (3) @(negedge clk);
        check_eq("red_hold",    int'(valor_a), 3'b100);
        check_eq("red_no_done", int'(done_a),  0);
        check_eq("red_addr_end", int'(addr_a), 15);

        // Red/green tie.
        fill(6, 6, 4, 8'hE0, 8'h1C, 8'h03, 8'h00);
        mem_a = pat;
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("tie_latency", lat, 19);
        check_eq("tie_valor",   int'(mon_valor), 3'b000);
`ifdef ANALYZER_COUNTS_OUT_EN
        check_eq("tie_cnt_r", int'(cr_a), 6);
        check_eq("tie_cnt_g", int'(cg_a), 6);
        check_eq("tie_cnt_b", int'(cb_a), 4);
`endif

        // Only MSBs count: 3 red, 4 green, 2 blue, 7 low-bit pixels.
        fill(3, 4, 2, 8'h80, 8'h10, 8'h02, 8'h6D);
        mem_a = pat;
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("msb_valor", int'(mon_valor), 3'b010);

        // MIN_COUNT=4: four blue is not enough, five is.
        sel = 1;
        fill(0, 0, 4, 8'hE0, 8'h1C, 8'h03, 8'hFF);
        mem_m = pat;
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("min4_latency", lat, 19);
        check_eq("min4_valor",   int'(mon_valor), 3'b000);
        fill(0, 0, 5, 8'hE0, 8'h1C, 8'h03, 8'hFF);
        mem_m = pat;
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("min5_valor",   int'(mon_valor), 3'b001);

        // Single pixel at a high base address.
        sel   = 2;
        mem_s = 8'h1C;
        run_scan(1, 'h4B00, lat, nrd, swp, bok);
        check_eq("one_latency", lat, 4);
        check_eq("one_reads",   nrd, 1);
        check_eq("one_addr",    swp, 1);
        check_eq("one_valor",   int'(mon_valor), 3'b010);

        // Reset mid-scan after a blue result.
        sel = 0;
        fill(2, 3, 11, 8'hE0, 8'h1C, 8'h03, 8'h00);
        mem_a = pat;
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("pre_rst_valor", int'(mon_valor), 3'b001);
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            init_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq("abort_valor", int'(valor_a), 0);
        check_eq("abort_busy",  int'(busy_a),  0);
        check_eq("abort_rd_en", int'(rd_a),    0);
        check_eq("abort_addr",  int'(addr_a),  0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        check_eq("abort_no_done", nd, 0);
        run_scan(16, 0, lat, nrd, swp, bok);
        check_eq("after_rst_latency", lat, 19);
        check_eq("after_rst_valor",   int'(mon_valor), 3'b001);

        // init held for 40 cycles: two back-to-back scans.
        fill(10, 3, 3, 8'hE0, 8'h1C, 8'h03, 8'h00);
        mem_a = pat;
        nd    = 0;
        d0    = -1;
        d1    = -1;
        rd20  = 0;
        ad20  = -1;
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 39) init_req = 1'b0;
            if (k == 20) begin
                rd20 = int'(rd_a);
                ad20 = int'(addr_a);
            end
            if (done_a) begin
                if (nd == 0) d0 = k;
                if (nd == 1) d1 = k;
                check_eq("held_valor", int'(valor_a), 3'b100);
                nd++;
            end
        end
        check_eq("held_scans",  nd, 2);
        check_eq("held_done0",  d0, 19);
        check_eq("held_done1",  d1, 39);
        check_eq("held_restart_rd",   rd20, 1);
        check_eq("held_restart_addr", ad20, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
